// File: rtl/tx_sequence_scheduler_if.sv
// AXI-stream style handshake bundle used by all streaming ports of the scheduler.
interface Axis_If #(
   parameter int WIDTH = 8
);
   logic             valid;
   logic             ready;
   logic             last;
   logic [WIDTH-1:0] data;

   modport Master (output valid, output data, output last, input ready);
   modport Slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/tx_sequence_scheduler.sv
// Transmit-chain step scheduler: replays a loaded table of {dwell, mux_cfg}
// steps, bracketing each run with AWG start/stop commands.
//
// state       | meaning
// ------------+------------------------------------------------------------
// S_IDLE      | table loads accepted, waiting for a start
// S_AWG_START | AWG start command (2'b01) presented
// S_CFG       | current step's mux config presented to the transmit chain
// S_DWELL     | dwell down-counter running for the current step
// S_ADVANCE   | single cycle: pick next step, wrap the loop, or finish
// S_AWG_STOP  | AWG stop command (2'b10) presented, then back to idle
module tx_sequence_scheduler #(
   parameter int CHANNELS      = 8,
   parameter int MUX_SEL_BITS  = $clog2(3*CHANNELS),
   parameter int MUX_CFG_WIDTH = MUX_SEL_BITS*CHANNELS,
   parameter int DWELL_BITS    = 32,
   parameter int DEPTH         = 16,
   parameter int LOOP_BITS     = 16
) (
   input  logic                      ps_clk,
   input  logic                      ps_reset_n,
   Axis_If.Slave                     ps_seq_write,
   Axis_If.Slave                     ps_seq_loops,
   Axis_If.Slave                     ps_seq_start_stop,
   Axis_If.Master                    ps_mux_config,
   Axis_If.Master                    ps_awg_start_stop,
   output logic [1+$clog2(DEPTH):0]  ps_seq_status
);
   localparam int IDX_W   = $clog2(DEPTH);
   localparam int PTR_W   = $clog2(DEPTH+1);
   localparam int ENTRY_W = DWELL_BITS + MUX_CFG_WIDTH;

   typedef enum logic [2:0] {
      S_IDLE, S_AWG_START, S_CFG, S_DWELL, S_ADVANCE, S_AWG_STOP
   } state_t;

   logic [ENTRY_W-1:0]       table_mem [DEPTH];

   state_t                   state_q, state_d;
   logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]         num_steps_q, num_steps_d;
   logic [LOOP_BITS-1:0]     loops_q, loops_d;
   logic [LOOP_BITS-1:0]     loop_cnt_q, loop_cnt_d;
   logic [IDX_W-1:0]         step_q, step_d;
   logic [DWELL_BITS-1:0]    dwell_cnt_q, dwell_cnt_d;
   logic                     error_q, error_d;
   logic                     stop_pend_q, stop_pend_d;
   logic                     wr_ready_q, wr_ready_d;
   logic                     awg_valid_q, awg_valid_d;
   logic [1:0]               awg_data_q, awg_data_d;
   logic                     mux_valid_q, mux_valid_d;
   logic [MUX_CFG_WIDTH-1:0] mux_data_q, mux_data_d;

   logic                     wr_beat, wr_full, start_req, stop_req, stop_now;
   logic                     mux_hs, awg_hs;
   logic [DWELL_BITS-1:0]    cur_dwell;
   logic                     unused_ok;

   assign wr_beat   = ps_seq_write.valid & wr_ready_q;
   assign wr_full   = (wr_ptr_q == PTR_W'(DEPTH));
   assign start_req = ps_seq_start_stop.valid & ps_seq_start_stop.data[0] & ~ps_seq_start_stop.data[1];
   assign stop_req  = ps_seq_start_stop.valid & ps_seq_start_stop.data[1];
   assign stop_now  = stop_pend_q | stop_req;
   assign mux_hs    = mux_valid_q & ps_mux_config.ready;
   assign awg_hs    = awg_valid_q & ps_awg_start_stop.ready;
   assign cur_dwell = table_mem[step_q][ENTRY_W-1 -: DWELL_BITS];

   assign ps_seq_write.ready      = wr_ready_q;
   assign ps_seq_loops.ready      = 1'b1;
   assign ps_seq_start_stop.ready = 1'b1;
   assign ps_mux_config.valid     = mux_valid_q;
   assign ps_mux_config.data      = mux_data_q;
   assign ps_mux_config.last      = 1'b0;
   assign ps_awg_start_stop.valid = awg_valid_q;
   assign ps_awg_start_stop.data  = awg_data_q;
   assign ps_awg_start_stop.last  = 1'b0;
   assign ps_seq_status           = {error_q, state_q != S_IDLE, step_q};
   assign unused_ok               = ^{ps_seq_loops.last, ps_seq_start_stop.last};

   // Table RAM write port; only beats below the full mark land in the table.
   always_ff @(posedge ps_clk) begin
      if (wr_beat && !wr_full) begin
         table_mem[wr_ptr_q[IDX_W-1:0]] <= ps_seq_write.data;
      end
   end

   // Next-state logic for the sequencer, table loader and output registers.
   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      num_steps_d = num_steps_q;
      loops_d     = loops_q;
      loop_cnt_d  = loop_cnt_q;
      step_d      = step_q;
      dwell_cnt_d = dwell_cnt_q;
      error_d     = error_q;
      stop_pend_d = stop_pend_q;
      awg_valid_d = awg_valid_q;
      awg_data_d  = awg_data_q;
      mux_valid_d = mux_valid_q;
      mux_data_d  = mux_data_q;

      if (ps_seq_loops.valid) begin
         loops_d = ps_seq_loops.data;
      end

      // A dropped last beat still rewinds the pointer so software can reload.
      if (wr_beat) begin
         if (wr_full) begin
            error_d = 1'b1;
            if (ps_seq_write.last) wr_ptr_d = '0;
         end else if (ps_seq_write.last) begin
            num_steps_d = wr_ptr_q + PTR_W'(1);
            wr_ptr_d    = '0;
         end else begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end
      end

      case (state_q)
         S_IDLE: begin
            if (start_req) begin
               if (num_steps_q == '0) begin
                  error_d = 1'b1;
               end else begin
                  error_d    = 1'b0;
                  step_d     = '0;
                  loop_cnt_d = loops_q;
                  state_d    = S_AWG_START;
               end
            end
         end
         S_AWG_START: begin
            if (awg_hs) state_d = stop_now ? S_AWG_STOP : S_CFG;
         end
         S_CFG: begin
            // The handshake cycle is the first dwell cycle of the step.
            if (mux_hs) begin
               if (stop_now) begin
                  state_d = S_AWG_STOP;
               end else if (cur_dwell <= DWELL_BITS'(1)) begin
                  state_d = S_ADVANCE;
               end else begin
                  dwell_cnt_d = cur_dwell - DWELL_BITS'(1);
                  state_d     = S_DWELL;
               end
            end
         end
         S_DWELL: begin
            if (stop_now) begin
               state_d = S_AWG_STOP;
            end else if (dwell_cnt_q == DWELL_BITS'(1)) begin
               state_d = S_ADVANCE;
            end else begin
               dwell_cnt_d = dwell_cnt_q - DWELL_BITS'(1);
            end
         end
         S_ADVANCE: begin
            if (stop_now) begin
               state_d = S_AWG_STOP;
            end else if (PTR_W'(step_q) + PTR_W'(1) < num_steps_q) begin
               step_d  = step_q + IDX_W'(1);
               state_d = S_CFG;
            end else if (loop_cnt_q == LOOP_BITS'(1)) begin
               state_d = S_AWG_STOP;
            end else begin
               step_d = '0;
               if (loop_cnt_q != '0) loop_cnt_d = loop_cnt_q - LOOP_BITS'(1);
               state_d = S_CFG;
            end
         end
         S_AWG_STOP: begin
            if (awg_hs) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (stop_req && state_q != S_IDLE) stop_pend_d = 1'b1;
      if (state_d == S_IDLE || state_d == S_AWG_STOP) stop_pend_d = 1'b0;

      if (awg_hs) begin
         awg_valid_d = 1'b0;
         awg_data_d  = 2'b00;
      end
      if (state_d == S_AWG_START && state_q != S_AWG_START) begin
         awg_valid_d = 1'b1;
         awg_data_d  = 2'b01;
      end
      if (state_d == S_AWG_STOP && state_q != S_AWG_STOP) begin
         awg_valid_d = 1'b1;
         awg_data_d  = 2'b10;
      end

      // Config word is registered on entry so it is stable when valid rises.
      if (mux_hs) mux_valid_d = 1'b0;
      if (state_d == S_CFG && state_q != S_CFG) begin
         mux_valid_d = 1'b1;
         mux_data_d  = table_mem[step_d][MUX_CFG_WIDTH-1:0];
      end

      wr_ready_d = (state_d == S_IDLE);
   end

   // State and output registers with asynchronous active-low reset.
   always_ff @(posedge ps_clk or negedge ps_reset_n) begin
      if (!ps_reset_n) begin
         state_q     <= S_IDLE;
         wr_ptr_q    <= '0;
         num_steps_q <= '0;
         loops_q     <= LOOP_BITS'(1);
         loop_cnt_q  <= '0;
         step_q      <= '0;
         dwell_cnt_q <= '0;
         error_q     <= 1'b0;
         stop_pend_q <= 1'b0;
         wr_ready_q  <= 1'b0;
         awg_valid_q <= 1'b0;
         awg_data_q  <= 2'b00;
         mux_valid_q <= 1'b0;
         mux_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         num_steps_q <= num_steps_d;
         loops_q     <= loops_d;
         loop_cnt_q  <= loop_cnt_d;
         step_q      <= step_d;
         dwell_cnt_q <= dwell_cnt_d;
         error_q     <= error_d;
         stop_pend_q <= stop_pend_d;
         wr_ready_q  <= wr_ready_d;
         awg_valid_q <= awg_valid_d;
         awg_data_q  <= awg_data_d;
         mux_valid_q <= mux_valid_d;
         mux_data_q  <= mux_data_d;
      end
   end
endmodule

// File: tb/tb_tx_sequence_scheduler.sv
// Directed bench for tx_sequence_scheduler: table-driven step timing plus
// hand-written abort, back-pressure, error and reset sequences.
module tb_tx_sequence_scheduler;
   localparam int CFG_W   = 40;
   localparam int DW      = 32;
   localparam int ENTRY_W = DW + CFG_W;

   logic       ps_clk = 1'b0;
   logic       ps_reset_n = 1'b0;
   logic [5:0] status;

   always #5 ps_clk = ~ps_clk;

   Axis_If #(.WIDTH(ENTRY_W)) wr_if ();
   Axis_If #(.WIDTH(16))      loops_if ();
   Axis_If #(.WIDTH(2))       ss_if ();
   Axis_If #(.WIDTH(CFG_W))   mux_if ();
   Axis_If #(.WIDTH(2))       awg_if ();

   tx_sequence_scheduler dut (
      .ps_clk            (ps_clk),
      .ps_reset_n        (ps_reset_n),
      .ps_seq_write      (wr_if),
      .ps_seq_loops      (loops_if),
      .ps_seq_start_stop (ss_if),
      .ps_mux_config     (mux_if),
      .ps_awg_start_stop (awg_if),
      .ps_seq_status     (status)
   );

   typedef struct {
      logic [CFG_W-1:0] cfg;
      logic [DW-1:0]    dwell;
      int               rel;
   } vec_t;

   vec_t vecs [6];

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   logic [CFG_W-1:0] cfg_d [$];
   int               cfg_t [$];
   logic [1:0]       awg_d [$];
   int               awg_t [$];
   int               stab_err = 0;
   logic             held = 1'b0;
   logic [CFG_W-1:0] held_data = '0;

   always @(posedge ps_clk) cyc++;

   // Handshake recorder and hold-stability watcher, sampled mid-cycle.
   always @(negedge ps_clk) begin
      if (mux_if.valid && mux_if.ready) begin
         cfg_d.push_back(mux_if.data);
         cfg_t.push_back(cyc);
      end
      if (awg_if.valid && awg_if.ready) begin
         awg_d.push_back(awg_if.data);
         awg_t.push_back(cyc);
      end
      if (mux_if.valid && !mux_if.ready) begin
         if (held && mux_if.data != held_data) stab_err++;
         held      = 1'b1;
         held_data = mux_if.data;
      end else begin
         if (held && !mux_if.valid) stab_err++;
         held = 1'b0;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge ps_clk);
      #2;
   endtask

   task automatic clear_q();
      cfg_d.delete(); cfg_t.delete(); awg_d.delete(); awg_t.delete();
   endtask

   task automatic ss_beat(input logic [1:0] d);
      ss_if.valid = 1'b1;
      ss_if.data  = d;
      tick();
      ss_if.valid = 1'b0;
      ss_if.data  = 2'b00;
   endtask

   task automatic loops_beat(input logic [15:0] v);
      loops_if.valid = 1'b1;
      loops_if.data  = v;
      tick();
      loops_if.valid = 1'b0;
   endtask

   task automatic wr_beat(input logic [DW-1:0] dwell, input logic [CFG_W-1:0] cfg, input logic last);
      int k = 0;
      wr_if.valid = 1'b1;
      wr_if.data  = {dwell, cfg};
      wr_if.last  = last;
      while (!wr_if.ready && k < 20) begin
         tick();
         k++;
      end
      tick();
      wr_if.valid = 1'b0;
      wr_if.last  = 1'b0;
   endtask

   task automatic wait_idle(input int budget, output int t_idle);
      int k = 0;
      while (status[4] && k < budget) begin
         tick();
         k++;
      end
      check("wait_idle_timeout", 64'(status[4]), 64'd0);
      t_idle = cyc;
   endtask

   task automatic wait_cfgs(input int n, input int budget);
      int k = 0;
      while (cfg_d.size() < n && k < budget) begin
         tick();
         k++;
      end
      check("wait_cfg_timeout", 64'(cfg_d.size()), 64'(n));
   endtask

   task automatic check_cfgs(input string tag, input int n);
      check({tag, "_cfg_count"}, 64'(cfg_d.size()), 64'(n));
      if (cfg_d.size() >= n) begin
         for (int i = 0; i < n; i++) begin
            check($sformatf("%s_cfg%0d_data", tag, i), 64'(cfg_d[i]), 64'(vecs[i].cfg));
            check($sformatf("%s_cfg%0d_time", tag, i), 64'(cfg_t[i] - cfg_t[0]), 64'(vecs[i].rel));
         end
      end
   endtask

   initial begin
      int t0, t_idle, tv;
      vecs[0] = '{cfg: 40'hA1B2C3D4E5, dwell: 32'd10, rel: 0};
      vecs[1] = '{cfg: 40'h0F1E2D3C4B, dwell: 32'd20, rel: 11};
      vecs[2] = '{cfg: 40'h5A5A5A5A5A, dwell: 32'd5,  rel: 32};
      vecs[3] = '{cfg: 40'hA1B2C3D4E5, dwell: 32'd10, rel: 38};
      vecs[4] = '{cfg: 40'h0F1E2D3C4B, dwell: 32'd20, rel: 49};
      vecs[5] = '{cfg: 40'h5A5A5A5A5A, dwell: 32'd5,  rel: 70};

      wr_if.valid = 0; wr_if.data = '0; wr_if.last = 0;
      loops_if.valid = 0; loops_if.data = '0; loops_if.last = 0;
      ss_if.valid = 0; ss_if.data = '0; ss_if.last = 0;
      mux_if.ready = 1; awg_if.ready = 1;

      // Reset state
      repeat (3) tick();
      check("rst_awg_valid", 64'(awg_if.valid), 64'd0);
      check("rst_awg_data", 64'(awg_if.data), 64'd0);
      check("rst_mux_valid", 64'(mux_if.valid), 64'd0);
      check("rst_mux_data", 64'(mux_if.data), 64'd0);
      check("rst_wr_ready", 64'(wr_if.ready), 64'd0);
      check("rst_status", 64'(status), 64'd0);
      ps_reset_n = 1'b1;
      repeat (2) tick();
      check("idle_wr_ready", 64'(wr_if.ready), 64'd1);

      // Single pass with reset-value loops=1
      for (int i = 0; i < 3; i++) wr_beat(vecs[i].dwell, vecs[i].cfg, i == 2);
      clear_q();
      t0 = cyc;
      ss_beat(2'b01);
      check("run1_busy", 64'(status[4]), 64'd1);
      tick();
      wr_if.valid = 1'b1; wr_if.data = {32'd3, 40'hDEADBEEF00}; wr_if.last = 1'b1;
      repeat (3) tick();
      check("run1_wr_ready_busy", 64'(wr_if.ready), 64'd0);
      tick();
      wr_if.valid = 1'b0; wr_if.last = 1'b0;
      wait_idle(300, t_idle);
      check("run1_awg_count", 64'(awg_d.size()), 64'd2);
      if (awg_d.size() == 2) begin
         check("run1_awg_start", 64'(awg_d[0]), 64'd1);
         check("run1_awg_stop", 64'(awg_d[1]), 64'd2);
         check("run1_start_latency", 64'(awg_t[0] - t0), 64'd1);
         check("run1_idle_after_stop", 64'(t_idle - awg_t[1]), 64'd1);
      end
      check_cfgs("run1", 3);
      if (cfg_t.size() == 3 && awg_t.size() == 2) begin
         check("run1_first_cfg", 64'(cfg_t[0] - awg_t[0]), 64'd1);
         check("run1_stop_after_c", 64'(awg_t[1] - cfg_t[2]), 64'd6);
      end
      check("run1_error", 64'(status[5]), 64'd0);
      check("run1_wr_ready_idle", 64'(wr_if.ready), 64'd1);

      // Two loops; loops=0 captured mid-run applies to the next run
      loops_beat(16'd2);
      clear_q();
      ss_beat(2'b01);
      repeat (4) tick();
      loops_beat(16'd0);
      wait_idle(500, t_idle);
      check_cfgs("run2", 6);
      check("run2_awg_count", 64'(awg_d.size()), 64'd2);
      if (awg_d.size() == 2 && cfg_t.size() == 6) begin
         check("run2_awg_stop", 64'(awg_d[1]), 64'd2);
         check("run2_stop_time", 64'(awg_t[1] - cfg_t[5]), 64'd6);
      end

      // Infinite loops, stop during DWELL of step 1 on the second pass
      clear_q();
      ss_beat(2'b01);
      wait_cfgs(5, 300);
      repeat (3) tick();
      check("inf_step_index", 64'(status[3:0]), 64'd1);
      t0 = cyc;
      ss_beat(2'b10);
      wait_idle(100, t_idle);
      check_cfgs("inf", 5);
      check("inf_awg_count", 64'(awg_d.size()), 64'd2);
      if (awg_d.size() == 2) begin
         check("inf_awg_stop", 64'(awg_d[1]), 64'd2);
         check("inf_stop_latency", 64'(awg_t[1] - t0), 64'd1);
      end

      // Back-pressure on config with stop raised while valid is held
      loops_beat(16'd1);
      mux_if.ready = 1'b0;
      clear_q();
      stab_err = 0;
      ss_beat(2'b01);
      tv = 0;
      for (int k = 0; k < 10 && !mux_if.valid; k++) tick();
      check("bp_valid_seen", 64'(mux_if.valid), 64'd1);
      tv = cyc;
      for (int k = 0; k < 7; k++) begin
         if (k == 2) ss_beat(2'b10);
         else tick();
      end
      mux_if.ready = 1'b1;
      wait_idle(100, t_idle);
      check("bp_stable", 64'(stab_err), 64'd0);
      check("bp_cfg_count", 64'(cfg_d.size()), 64'd1);
      check("bp_awg_count", 64'(awg_d.size()), 64'd2);
      if (cfg_d.size() == 1 && awg_d.size() == 2) begin
         check("bp_cfg_data", 64'(cfg_d[0]), 64'(vecs[0].cfg));
         check("bp_cfg_wait", 64'(cfg_t[0] - tv), 64'd7);
         check("bp_awg_stop", 64'(awg_d[1]), 64'd2);
         check("bp_stop_after_cfg", 64'(awg_t[1] - cfg_t[0]), 64'd1);
      end

      // Start and stop in one beat from idle
      clear_q();
      ss_beat(2'b11);
      repeat (10) tick();
      check("ss_both_traffic", 64'(cfg_d.size() + awg_d.size()), 64'd0);
      check("ss_both_status", 64'(status), 64'd0);

      // Asynchronous reset in the middle of DWELL
      clear_q();
      ss_beat(2'b01);
      wait_cfgs(1, 20);
      repeat (3) tick();
      check("arst_pre_busy", 64'(status[4]), 64'd1);
      #1 ps_reset_n = 1'b0;
      #1;
      check("arst_status", 64'(status), 64'd0);
      check("arst_mux_valid", 64'(mux_if.valid), 64'd0);
      check("arst_awg_valid", 64'(awg_if.valid), 64'd0);
      check("arst_wr_ready", 64'(wr_if.ready), 64'd0);
      tick();
      ps_reset_n = 1'b1;
      repeat (2) tick();
      check("arst_no_stop", 64'(awg_d.size()), 64'd1);
      ss_beat(2'b01);
      tick();
      check("empty_error", 64'(status[5]), 64'd1);
      check("empty_busy", 64'(status[4]), 64'd0);
      repeat (5) tick();
      check("empty_no_traffic", 64'(awg_d.size() + cfg_d.size()), 64'd2);

      // Overfill: 17 beats without last
      ps_reset_n = 1'b0;
      tick();
      ps_reset_n = 1'b1;
      repeat (2) tick();
      clear_q();
      for (int i = 0; i < 16; i++) wr_beat(32'(i + 1), 40'(i), 1'b0);
      check("fill16_error", 64'(status[5]), 64'd0);
      wr_beat(32'd1, 40'h77, 1'b0);
      check("fill17_error", 64'(status[5]), 64'd1);
      ss_beat(2'b01);
      repeat (3) tick();
      check("fill17_no_run", 64'(status[4]), 64'd0);
      check("fill17_no_traffic", 64'(awg_d.size() + cfg_d.size()), 64'd0);

      // Single step with dwell 0; accepted start clears a sticky error
      ps_reset_n = 1'b0;
      tick();
      ps_reset_n = 1'b1;
      repeat (2) tick();
      ss_beat(2'b01);
      check("d0_pre_error", 64'(status[5]), 64'd1);
      wr_beat(32'd0, vecs[2].cfg, 1'b1);
      clear_q();
      ss_beat(2'b01);
      check("d0_error_cleared", 64'(status[5]), 64'd0);
      wait_idle(50, t_idle);
      check("d0_cfg_count", 64'(cfg_d.size()), 64'd1);
      check("d0_awg_count", 64'(awg_d.size()), 64'd2);
      if (cfg_d.size() == 1 && awg_d.size() == 2) begin
         check("d0_cfg_data", 64'(cfg_d[0]), 64'(vecs[2].cfg));
         check("d0_stop_time", 64'(awg_t[1] - cfg_t[0]), 64'd2);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/tx_sequence_scheduler.md
# tx_sequence_scheduler

Programmable step scheduler for the transmit chain, in the PS clock domain. It replays a table of up to DEPTH steps; each step holds a channel-mux configuration word and a dwell time. Each step's configuration goes to the transmit chain's `ps_channel_mux_config` input. The block arms the AWG through `ps_awg_start_stop` at the start of a run and stops it at the end. Software loads the table once and can then switch signal sources (AWG/DDS/triangle) on a deterministic, cycle-counted schedule.

## Interface
- CHANNELS, 8, DAC channels in the transmit chain
- MUX_SEL_BITS, $clog2(3*CHANNELS), per-channel mux select width
- MUX_CFG_WIDTH, MUX_SEL_BITS*CHANNELS, mux configuration word width
- DWELL_BITS, 32, dwell counter width (ps_clk cycles)
- DEPTH, 16, step table entries
- LOOP_BITS, 16, loop counter width

- ps_clk  in  1  sole clock
- ps_reset_n  in  1  reset, asynchronous assert, active-low (one clock; reset is asynchronous and active-low)
- ps_seq_write  Axis_If.Slave  DWELL_BITS+MUX_CFG_WIDTH  table load: data = {dwell, mux_cfg}; last = final entry
- ps_seq_loops  Axis_If.Slave  LOOP_BITS  passes through the table per run; 0 = infinite
- ps_seq_start_stop  Axis_If.Slave  2  bit0 start, bit1 stop
- ps_mux_config  Axis_If.Master  MUX_CFG_WIDTH  to transmit chain channel-mux config
- ps_awg_start_stop  Axis_If.Master  2  to AWG: 2'b01 start, 2'b10 stop
- ps_seq_status  out  2+$clog2(DEPTH)  {error, busy, step_index}

## Operation
- Registers:
  - table RAM of DEPTH entries
  - write pointer wr_ptr
  - num_steps (0..DEPTH)
  - loops (reset value 1)
  - step index
  - loop counter
  - dwell counter
- Table load:
  - ps_seq_write.ready = 1 only in IDLE.
  - Each beat writes entry wr_ptr, then wr_ptr++.
  - On a beat with last: num_steps = wr_ptr+1 and wr_ptr clears.
  - A beat with wr_ptr==DEPTH is dropped and sets error.
  - num_steps is unchanged until a last beat arrives.
- ps_seq_loops: ready always 1. A value captured while busy takes effect on the next run.
- ps_seq_start_stop: ready always 1.
  - start in IDLE with num_steps>0: begin run.
  - start in IDLE with num_steps==0: set error, remain IDLE.
  - start while busy: ignored.
  - stop while busy: abort; stop while idle: ignored.
  - start and stop in the same beat: stop wins.
- Error bit: sticky; cleared by the next accepted start.
- FSM:
  - IDLE → AWG_START on valid start: step=0, loop_cnt=loops.
  - AWG_START: ps_awg_start_stop.valid=1, data=2'b01. On handshake → CFG.
  - CFG: ps_mux_config.valid=1, data=table[step].mux_cfg. On handshake, dwell_cnt=max(table[step].dwell,1) → DWELL.
  - DWELL: dwell_cnt-- each cycle. At 1 → ADVANCE.
  - ADVANCE (single cycle):
    - step<num_steps-1: step++ → CFG.
    - else, loop_cnt==1 (finite): → AWG_STOP.
    - else: step=0; loop_cnt-- unless infinite → CFG.
  - AWG_STOP: valid=1, data=2'b10. On handshake → IDLE.
- Abort (stop accepted):
  - From DWELL/ADVANCE: → AWG_STOP next cycle.
  - From AWG_START/CFG: the master holds valid and data until its handshake completes (AXI rule: never retract valid), then → AWG_STOP.
  - A pending stop is latched so it is not lost.
- busy = state != IDLE.
- step_index = current step.

## Timing
- Reset values:
  - all master valids 0, data 0
  - ps_seq_write.ready 0
  - status 0
  - num_steps 0, loops 1
  - state IDLE
  - Reset assertion takes effect immediately (asynchronous), including mid-run or mid-handshake. The AWG is not sent a stop.
- Start latency: start accepted at cycle T → ps_awg_start_stop.valid at T+1.
- Step period: with an immediate ready on ps_mux_config, consecutive config handshakes are spaced exactly dwell+1 cycles (dwell cycles of DWELL plus one ADVANCE). Back-pressure adds its cycles to the step.
- Table lookup is registered. mux_cfg data must be stable on the first cycle valid rises.
- Dwell 0 behaves as dwell 1.

## Test plan
- Load 3 steps (cfg A/B/C, dwell 10/20/5), loops=1, start, sinks always ready:
  - AWG 2'b01 handshake, then configs A,B,C at relative cycles 0,11,32.
  - Then AWG 2'b10; busy falls after the stop handshake.
- loops=2 on the same table: sequence A,B,C,A,B,C, then stop. loops=0 repeats until stop; stop issued in DWELL of step 1 → 2'b10 within 1 cycle, no further config.
- Back-pressure: ps_mux_config.ready low 7 cycles in CFG with stop asserted meanwhile:
  - valid and data held stable throughout.
  - Config handshake completes, then AWG stop, then IDLE.
- Start with empty table:
  - error=1, no master traffic.
  - Load 17 entries into DEPTH=16: 17th dropped, error=1, num_steps stays 0 (no last accepted).
- Writes during run: ps_seq_write.ready=0 while busy. Start and stop in the same beat from IDLE: no traffic.
- Assert ps_reset_n low mid-DWELL: all valids 0 and status 0 asynchronously. After release, start with num_steps==0 sets error.
